// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution engine: default geometry,
// weight-port address map and the kernel tap storage type.
package conv_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ACC_W  = 20;
    localparam int DEFAULT_IMG_W  = 226;
    localparam int DEFAULT_IMG_H  = 226;

    localparam int TAP_W    = 8;
    localparam int BIAS_W   = 16;
    localparam int NUM_TAPS = 9;

    localparam logic [3:0] W_ADDR_TAP_LAST = 4'd8;
    localparam logic [3:0] W_ADDR_BIAS     = 4'd9;

    typedef logic signed [TAP_W-1:0] tap_t;
    typedef tap_t [NUM_TAPS-1:0]     tap_array_t;

endpackage

// File: rtl/conv_row_mac.sv
// One kernel row: three unsigned-pixel x signed-tap products registered in stage 1,
// their sign-extended sum registered in stage 2.
module conv_row_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        pix_0,
    input  logic [DATA_W-1:0]        pix_1,
    input  logic [DATA_W-1:0]        pix_2,
    input  logic signed [TAP_W-1:0]  tap_0,
    input  logic signed [TAP_W-1:0]  tap_1,
    input  logic signed [TAP_W-1:0]  tap_2,
    output logic signed [ACC_W-1:0]  row_sum
);

    localparam int PROD_W = DATA_W + 1 + TAP_W;

    logic [DATA_W-1:0]        pix [3];
    logic signed [TAP_W-1:0]  tap [3];
    logic signed [PROD_W-1:0] prod_d [3];
    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;

    assign pix[0] = pix_0;
    assign pix[1] = pix_1;
    assign pix[2] = pix_2;
    assign tap[0] = tap_0;
    assign tap[1] = tap_1;
    assign tap[2] = tap_2;

    // Pixels are zero-extended by one bit so they multiply as non-negative signed values.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod_d[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(tap[i]);
        end
        sum_d = ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]) + ACC_W'(prod_q[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sum_q <= sum_d;
        end
    end

    assign row_sum = sum_q;

endmodule

// File: rtl/conv3x3_mac.sv
// Pipelined 3x3 convolution (3 register stages) with raster in-frame tagging.
// Define CONV3X3_RELU_EN to clamp negative results to zero in the output stage.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEFAULT_IMG_W,
    parameter int IMG_H  = DEFAULT_IMG_H,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       pixel_00,
    input  logic [DATA_W-1:0]       pixel_01,
    input  logic [DATA_W-1:0]       pixel_02,
    input  logic [DATA_W-1:0]       pixel_10,
    input  logic [DATA_W-1:0]       pixel_11,
    input  logic [DATA_W-1:0]       pixel_12,
    input  logic [DATA_W-1:0]       pixel_20,
    input  logic [DATA_W-1:0]       pixel_21,
    input  logic [DATA_W-1:0]       pixel_22,
    input  logic                    w_we,
    input  logic [3:0]              w_addr,
    input  logic [15:0]             w_data,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    tap_array_t               taps_q, taps_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic [COL_W-1:0]         col_q, col_d, cur_col;
    logic [ROW_W-1:0]         row_q, row_d, cur_row;
    logic                     win_valid, win_last;

    logic                     v1_q, v1_d, l1_q, l1_d;
    logic                     v2_q, v2_d, l2_q, l2_d;
    logic signed [BIAS_W-1:0] bias1_q, bias1_d, bias2_q, bias2_d;

    logic signed [ACC_W-1:0]  row0_sum, row1_sum, row2_sum, final_sum;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;

    always_comb begin
        taps_d = taps_q;
        bias_d = bias_q;
        if (w_we) begin
            if (w_addr <= W_ADDR_TAP_LAST) begin
                taps_d[w_addr] = w_data[TAP_W-1:0];
            end else if (w_addr == W_ADDR_BIAS) begin
                bias_d = w_data;
            end
        end
    end

    // frame_start re-homes the raster position before the current window is classified.
    always_comb begin
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        col_d   = cur_col;
        row_d   = cur_row;
        if (in_valid) begin
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
        end
        win_valid = in_valid && (cur_col >= COL_W'(2)) && (cur_row >= ROW_W'(2));
        win_last  = win_valid && (cur_col == COL_W'(IMG_W - 1)) && (cur_row == ROW_W'(IMG_H - 1));
    end

    conv_row_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_row0 (
        .clk(clk), .rst(rst),
        .pix_0(pixel_00), .pix_1(pixel_01), .pix_2(pixel_02),
        .tap_0(taps_q[0]), .tap_1(taps_q[1]), .tap_2(taps_q[2]),
        .row_sum(row0_sum)
    );

    conv_row_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_row1 (
        .clk(clk), .rst(rst),
        .pix_0(pixel_10), .pix_1(pixel_11), .pix_2(pixel_12),
        .tap_0(taps_q[3]), .tap_1(taps_q[4]), .tap_2(taps_q[5]),
        .row_sum(row1_sum)
    );

    conv_row_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_row2 (
        .clk(clk), .rst(rst),
        .pix_0(pixel_20), .pix_1(pixel_21), .pix_2(pixel_22),
        .tap_0(taps_q[6]), .tap_1(taps_q[7]), .tap_2(taps_q[8]),
        .row_sum(row2_sum)
    );

    // Bias travels with its window so a mid-stream bias write affects only later windows.
    always_comb begin
        v1_d    = win_valid;
        l1_d    = win_last;
        bias1_d = bias_q;
        v2_d    = v1_q;
        l2_d    = l1_q;
        bias2_d = bias1_q;
        final_sum = row0_sum + row1_sum + row2_sum + ACC_W'(bias2_q);
`ifdef CONV3X3_RELU_EN
        out_data_d = final_sum[ACC_W-1] ? '0 : final_sum;
`else
        out_data_d = final_sum;
`endif
        out_valid_d = v2_q;
        out_last_d  = l2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q      <= '0;
            bias_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            bias1_q     <= '0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            bias2_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            bias_q      <= bias_d;
            col_q       <= col_d;
            row_q       <= row_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            bias1_q     <= bias1_d;
            v2_q        <= v2_d;
            l2_q        <= l2_d;
            bias2_q     <= bias2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized self-checking bench for conv3x3_mac on a small frame, compared against a
// cycle-indexed reference model of the convolution and raster rules.
module tb_conv3x3_mac;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int MAXCYC = 4096;
`ifdef CONV3X3_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          in_valid;
    logic [DW-1:0] pix [9];
    logic          w_we;
    logic [3:0]    w_addr;
    logic [15:0]   w_data;
    logic          out_valid;
    logic          out_last;
    logic [AW-1:0] out_data;

    always #5 clk = ~clk;

    conv3x3_mac #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .pixel_00(pix[0]), .pixel_01(pix[1]), .pixel_02(pix[2]),
        .pixel_10(pix[3]), .pixel_11(pix[4]), .pixel_12(pix[5]),
        .pixel_20(pix[6]), .pixel_21(pix[7]), .pixel_22(pix[8]),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        bit valid;
        bit last;
        bit chk_data;
        int data;
    } exp_t;

    exp_t exp_q [MAXCYC];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_last = 0;
    int   last_vdata = 0;
    int   m_col = 0;
    int   m_row = 0;
    int   m_tap [9];
    int   m_bias = 0;

    task automatic checkOutput(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
        end
    endtask

    // Records the expectation for the inputs now driven, advances one clock, then checks.
    task automatic applyStimulus();
        exp_t e;
        int   acc;
        if (cyc + 4 >= MAXCYC) begin
            $display("[TB] FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXCYC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        e.valid = 0; e.last = 0; e.chk_data = 0; e.data = 0;
        if (rst) begin
            m_col = 0; m_row = 0; m_bias = 0;
            foreach (m_tap[i]) m_tap[i] = 0;
            for (int k = 1; k <= 3; k++) begin
                exp_q[cyc+k].valid = 0; exp_q[cyc+k].last = 0;
                exp_q[cyc+k].chk_data = 1; exp_q[cyc+k].data = 0;
            end
        end else begin
            if (frame_start) begin
                m_col = 0; m_row = 0;
            end
            if (in_valid) begin
                acc = m_bias;
                for (int i = 0; i < 9; i++) acc += int'(pix[i]) * m_tap[i];
                if (RELU && acc < 0) acc = 0;
                e.valid    = (m_col >= 2) && (m_row >= 2);
                e.last     = e.valid && (m_col == W - 1) && (m_row == H - 1);
                e.chk_data = e.valid;
                e.data     = acc;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end
            end
            exp_q[cyc+3] = e;
            if (w_we) begin
                if (w_addr < 9) m_tap[w_addr] = int'($signed(w_data[7:0]));
                else if (w_addr == 9) m_bias = int'($signed(w_data));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            n_valid++;
            last_vdata = int'($signed(out_data));
        end
        if (out_last === 1'b1) n_last++;
        checkOutput("out_valid", int'(out_valid), int'(exp_q[cyc].valid));
        checkOutput("out_last", int'(out_last), int'(exp_q[cyc].last));
        if (exp_q[cyc].chk_data) checkOutput("out_data", int'($signed(out_data)), exp_q[cyc].data);
    endtask

    task automatic idleInputs();
        rst = 0; frame_start = 0; in_valid = 0; w_we = 0; w_addr = '0; w_data = '0;
        foreach (pix[i]) pix[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic writeWeight(input logic [3:0] a, input logic [15:0] d);
        idleInputs();
        w_we = 1; w_addr = a; w_data = d;
        applyStimulus();
        w_we = 0;
    endtask

    // mode 0: random image, 1: ramp image, 2: all pixels 255
    task automatic streamFrame(input int mode, input int gap_pct, input int wr_pct, input int rst_at);
        logic [DW-1:0] img [H][W];
        int r, c;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (mode == 1) ? DW'((y * W + x) & 255) :
                            (mode == 2) ? DW'(255) : DW'($urandom_range(0, 255));
        for (int p = 0; p < W * H; p++) begin
            r = p / W;
            c = p % W;
            if (p == 0 && $urandom_range(0, 1) == 1) begin
                idleInputs();
                frame_start = 1;
                applyStimulus();
            end
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                idleInputs();
                applyStimulus();
            end
            idleInputs();
            in_valid    = 1;
            frame_start = (p == 0);
            if (mode == 2) foreach (pix[i]) pix[i] = DW'(255);
            else if (r >= 2 && c >= 2)
                for (int i = 0; i < 9; i++) pix[i] = img[r-2+i/3][c-2+i%3];
            if (wr_pct > 0 && $urandom_range(0, 99) < wr_pct) begin
                w_we = 1; w_addr = 4'($urandom_range(0, 15)); w_data = 16'($urandom);
            end
            rst = (p == rst_at);
            applyStimulus();
        end
        idleInputs();
    endtask

    initial begin
        foreach (m_tap[i]) m_tap[i] = 0;
        idleInputs();
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        for (int k = 0; k < 3; k++) applyStimulus();

        // identity kernel over a ramp image, full-frame pulse counts
        writeWeight(4'd4, 16'd1);
        n_valid = 0; n_last = 0;
        streamFrame(1, 0, 0, -1);
        for (int k = 0; k < 4; k++) applyStimulus();
        checkOutput("valid_count", n_valid, (W - 2) * (H - 2));
        checkOutput("last_count", n_last, 1);

        // most negative kernel and bias with saturated pixels
        for (int a = 0; a < 9; a++) writeWeight(4'(a), 16'h0080);
        writeWeight(4'd9, 16'h8000);
        streamFrame(2, 10, 0, -1);
        for (int k = 0; k < 4; k++) applyStimulus();
        checkOutput("extreme_result", last_vdata, RELU ? 0 : -326528);

        // random kernels, gaps, mid-stream writes, one mid-frame reset
        for (int f = 0; f < 5; f++) begin
            for (int a = 0; a < 10; a++) writeWeight(4'(a), 16'($urandom));
            streamFrame(0, 20, 15, (f == 2) ? 17 : -1);
        end
        for (int k = 0; k < 4; k++) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac.md
# conv3x3_mac

Pipelined 3×3 convolution engine that sits directly downstream of the 3×3 window line buffer. Each cycle it accepts one 9-pixel window, multiplies it against a locally stored signed 3×3 kernel plus bias, and emits one signed accumulator result. Raster counters mark only windows lying fully inside the frame as valid, so the following stage sees exactly (IMG_W−2)×(IMG_H−2) results per frame.

## Interface
Parameters:
- IMG_W, 226: frame width in pixels, including padding columns.
- IMG_H, 226: frame height in rows, including padding rows.
- DATA_W, 8: pixel width, unsigned.
- ACC_W, 20: result width, signed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  clears the raster counters; applies to the pixel accepted in the same cycle.
- in_valid  in  1  window ports hold the window whose bottom-right pixel is the current raster position.
- pixel_00 … pixel_22  in  DATA_W each  window, row-major; pixel_rc = row r, column c.
- w_we  in  1  kernel/bias write strobe.
- w_addr  in  4  0–8 = kernel taps row-major; 9 = bias; 10–15 ignored.
- w_data  in  16  signed; taps use bits [7:0], bias uses all 16 bits.
- out_valid  out  1  out_data holds a valid result.
- out_data  out  ACC_W  signed convolution result.
- out_last  out  1  high with the final result of a frame.

## Operation
- Raster counters col (0..IMG_W−1) and row (0..IMG_H−1) advance only on in_valid. col wraps to 0 and increments row. row wraps to 0 after IMG_H−1.
- frame_start with in_valid: this pixel takes col=0, row=0. frame_start without in_valid: the counters clear and the next in_valid takes position 0,0.
- A window is in-frame when col≥2 and row≥2. Other accepted windows are processed but carry valid=0 down the pipeline.
- out_last marks the window at col=IMG_W−1, row=IMG_H−1.
- Arithmetic: each product is pixel (zero-extended to 9 bits, signed) × tap (signed 8), giving a 17-bit signed result.
  - Three row sums of three products each, sign-extended to ACC_W.
  - Final result = row0 + row1 + row2 + sign-extended bias.
  - Worst case |result| ≤ 9·255·128 + 32768 = 326528 < 2^19. No overflow at ACC_W = 20, so no saturation logic.
- Weight writes: a write lands in the register at the clock edge. Windows accepted in the cycle after the write use the new value; the window accepted in the write cycle uses the old value. Writes are allowed during streaming.
- No backpressure; the consumer must accept one result per cycle.

## Timing
- Stage 1: register the products and the valid/last tags.
- Stage 2: register the three row sums.
- Stage 3: register final sum + bias into out_data, out_valid and out_last.
- Latency: window accepted at edge N produces its output at edge N+3. Throughput is 1 window per cycle.
- When out_valid is low, out_data holds the last pipeline value; consumers ignore it.
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0.
  - All pipeline valid tags = 0; col = row = 0.
  - All taps and bias = 0.
- Reset mid-frame: in-flight results are discarded (no out_valid in the 3 cycles after reset). The kernel must be reloaded.
- Simultaneous rst with w_we or in_valid: rst wins.

## Configuration
- CONV3X3_RELU_EN defined: stage 3 clamps negative results to 0. Applies to every valid result; out_valid timing is unchanged.
- Not defined: out_data is the raw signed sum.

## Structure
- Shared package conv_pkg holds:
  - DATA_W, ACC_W, IMG_W, IMG_H defaults.
  - Tap address constants (W_ADDR_BIAS = 9).
  - The tap array type.
- Sub-module conv_row_mac: three pixel/tap pairs in, registered 17-bit products, registered ACC_W row sum. It is instantiated three times.
- The top level owns the weight registers, raster counters, tag pipeline, final adder and the ReLU option.

## Test plan
- Identity kernel: tap_11 = 1, all others 0, bias = 0. Stream a 226×226 ramp. Expect the centre pixel on every output, 224×224 out_valid pulses, and one out_last.
- All taps = −128, bias = −32768, all pixels = 255. Expect out_data = −326528, no wrap. With CONV3X3_RELU_EN defined, expect 0.
- Latency: single window of all ones, taps = 1, bias = 5, accepted at cycle 10 with counters preset in-frame. Expect out_data = 14 with out_valid at cycle 13, and out_valid low otherwise.
- Border masking: after frame_start, the first 2·226 + 2 in_valid pixels give no out_valid. Pixel 455 (row 2, col 3 counting from 0) is the second valid output.
- Write during stream: change tap_00 from 1 to 2 at cycle N while streaming. The window at N uses 1 and the window at N+1 uses 2.
- Reset mid-frame: assert rst for 1 cycle with 3 windows in flight. Expect no out_valid for the next 3 cycles and out_data = 0.
